// File: rtl/vcmd_tx.sv
// vcmd_tx - host-side encoder for the video command byte stream.
//
// Turns VRAM write requests (19-bit address + 8-bit data) into the byte
// protocol understood by the video command receiver. A discontiguous write
// is preceded by a SetAddr command (0x01, page, high, low) sent in command
// mode. Writes that continue the previous address are streamed as raw data
// bytes in data mode.
//
// Ports:
//   Clk             system clock, rising edge
//   Reset           asynchronous, active-high reset
//   WriteValid      write request present
//   WriteAddr[18:0] VRAM byte address of the request
//   WriteData[7:0]  VRAM data byte of the request
//   WriteReady      request accepted when WriteValid & WriteReady
//   ByteOut[7:0]    protocol byte to the link (registered)
//   ByteValid       ByteOut valid, held until ByteReady (registered)
//   ByteReady       link accepts ByteOut this cycle
//   DataModeEnable  0 = command bytes, 1 = data bytes (registered)
//
// Parameter:
//   IDLE_CYCLES     idle cycles in data mode before DataModeEnable drops,
//                   0 disables the timeout

module vcmd_tx #(
  parameter int IDLE_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        WriteValid,
  input  logic [18:0] WriteAddr,
  input  logic [7:0]  WriteData,
  output logic        WriteReady,
  output logic [7:0]  ByteOut,
  output logic        ByteValid,
  input  logic        ByteReady,
  output logic        DataModeEnable
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_PAGE,
    S_HIGH,
    S_LOW,
    S_MODE,
    S_DATA,
    S_UNMODE
  } state_t;

  localparam int CW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [CW-1:0] IDLE_LAST = CW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);

  state_t        r_state;
  state_t        w_nextState;
  logic [18:0]   r_holdAddr;
  logic [7:0]    r_holdData;
  logic [18:0]   r_expAddr;
  logic          r_expAddrValid;
  logic [CW-1:0] r_idleCnt;
  logic [7:0]    r_byteOut;
  logic          r_byteValid;
  logic          r_dataMode;

  logic          w_accept;
  logic          w_contig;
  logic          w_idleCounting;
  logic          w_timeout;
  logic [18:0]   w_holdAddrNext;
  logic [7:0]    w_holdDataNext;
  logic [7:0]    w_nextByteOut;
  logic          w_nextByteValid;
  logic          w_nextDataMode;

  assign WriteReady     = (r_state == S_IDLE) && !Reset;
  assign ByteOut        = r_byteOut;
  assign ByteValid      = r_byteValid;
  assign DataModeEnable = r_dataMode;

  assign w_accept = (r_state == S_IDLE) && WriteValid;

  // A matching address only counts once a data byte has actually gone out,
  // so the first request after reset always carries a full SetAddr.
  assign w_contig = r_expAddrValid && (WriteAddr == r_expAddr);

  // The idle timeout only runs while parked in data mode with nothing
  // arriving; acceptance or any other state keeps the counter cleared.
  assign w_idleCounting = (IDLE_CYCLES > 0) && (r_state == S_IDLE) &&
                          r_dataMode && !WriteValid;
  assign w_timeout      = w_idleCounting && (r_idleCnt == IDLE_LAST);

  // The buffer contents as they will be after this edge, so a byte state
  // entered straight from IDLE already shows the new request's fields.
  assign w_holdAddrNext = w_accept ? WriteAddr : r_holdAddr;
  assign w_holdDataNext = w_accept ? WriteData : r_holdData;

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Byte states only advance on the link handshake, so
  // back-pressure stalls the sequence in place.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (WriteValid) begin
          if (w_contig && r_dataMode) begin
            w_nextState = S_DATA;
          end else if (w_contig) begin
            w_nextState = S_MODE;
          end else if (r_dataMode) begin
            w_nextState = S_UNMODE;
          end else begin
            w_nextState = S_CMD;
          end
        end
      end
      S_CMD:    if (ByteReady) w_nextState = S_PAGE;
      S_PAGE:   if (ByteReady) w_nextState = S_HIGH;
      S_HIGH:   if (ByteReady) w_nextState = S_LOW;
      S_LOW:    if (ByteReady) w_nextState = S_MODE;
      S_MODE:   w_nextState = S_DATA;
      S_DATA:   if (ByteReady) w_nextState = S_IDLE;
      S_UNMODE: w_nextState = S_CMD;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Output logic. The byte outputs are computed from the state being
  // entered and then registered, so ByteReady never reaches the outputs
  // combinationally. The mode flag only changes in MODE, UNMODE or on the
  // idle timeout, all of which have ByteValid low.
  always_comb begin
    w_nextByteValid = 1'b0;
    w_nextByteOut   = r_byteOut;
    case (w_nextState)
      S_CMD: begin
        w_nextByteValid = 1'b1;
        w_nextByteOut   = 8'h01;
      end
      S_PAGE: begin
        w_nextByteValid = 1'b1;
        w_nextByteOut   = {5'b0, w_holdAddrNext[18:16]};
      end
      S_HIGH: begin
        w_nextByteValid = 1'b1;
        w_nextByteOut   = w_holdAddrNext[15:8];
      end
      S_LOW: begin
        w_nextByteValid = 1'b1;
        w_nextByteOut   = w_holdAddrNext[7:0];
      end
      S_DATA: begin
        w_nextByteValid = 1'b1;
        w_nextByteOut   = w_holdDataNext;
      end
      default: begin
        w_nextByteValid = 1'b0;
      end
    endcase

    w_nextDataMode = r_dataMode;
    if (r_state == S_MODE) begin
      w_nextDataMode = 1'b1;
    end else if (r_state == S_UNMODE || w_timeout) begin
      w_nextDataMode = 1'b0;
    end
  end

  // Registered outputs, request buffer, expected-address tracker and idle
  // counter. The expected address wraps naturally at 19 bits, which makes
  // 0x7FFFF -> 0x00000 contiguous.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_byteOut      <= 8'h00;
      r_byteValid    <= 1'b0;
      r_dataMode     <= 1'b0;
      r_holdAddr     <= '0;
      r_holdData     <= '0;
      r_expAddr      <= '0;
      r_expAddrValid <= 1'b0;
      r_idleCnt      <= '0;
    end else begin
      r_byteOut   <= w_nextByteOut;
      r_byteValid <= w_nextByteValid;
      r_dataMode  <= w_nextDataMode;

      if (w_accept) begin
        r_holdAddr <= WriteAddr;
        r_holdData <= WriteData;
      end

      if (r_state == S_DATA && ByteReady) begin
        r_expAddr      <= r_holdAddr + 19'd1;
        r_expAddrValid <= 1'b1;
      end

      if (w_idleCounting && !w_timeout) begin
        r_idleCnt <= r_idleCnt + CW'(1);
      end else begin
        r_idleCnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vcmd_tx.sv
// tb_vcmd_tx - directed testbench for vcmd_tx.
//
// Each vector describes one clock cycle: the outputs expected during that
// cycle and the inputs driven for it. Outputs are compared and inputs are
// driven on the falling edge, so the rising edge samples settled inputs.

module tb_vcmd_tx;

  logic        Clk;
  logic        Reset;
  logic        WriteValid;
  logic [18:0] WriteAddr;
  logic [7:0]  WriteData;
  logic        WriteReady;
  logic [7:0]  ByteOut;
  logic        ByteValid;
  logic        ByteReady;
  logic        DataModeEnable;

  int checks;
  int errors;

  typedef struct {
    logic        wv;
    logic [18:0] addr;
    logic [7:0]  data;
    logic        br;
    logic        expWr;
    logic        expBv;
    logic [7:0]  expBo;
    logic        expDme;
  } vec_t;

  vec_t vecs[$];

  vcmd_tx #(.IDLE_CYCLES(16)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .WriteValid     (WriteValid),
    .WriteAddr      (WriteAddr),
    .WriteData      (WriteData),
    .WriteReady     (WriteReady),
    .ByteOut        (ByteOut),
    .ByteValid      (ByteValid),
    .ByteReady      (ByteReady),
    .DataModeEnable (DataModeEnable)
  );

  // Free-running 10 ns clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic vec_t mkVec(logic wv, logic [18:0] addr, logic [7:0] data,
                                 logic br, logic expWr, logic expBv,
                                 logic [7:0] expBo, logic expDme);
    vec_t v;
    v.wv = wv; v.addr = addr; v.data = data; v.br = br;
    v.expWr = expWr; v.expBv = expBv; v.expBo = expBo; v.expDme = expDme;
    return v;
  endfunction

  task automatic checkVal(string name, logic [18:0] act, logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ByteOut is only meaningful while ByteValid is expected high.
  task automatic checkOutput(vec_t v, string tag);
    checkVal({tag, " WriteReady"}, 19'(WriteReady), 19'(v.expWr));
    checkVal({tag, " ByteValid"}, 19'(ByteValid), 19'(v.expBv));
    checkVal({tag, " DataModeEnable"}, 19'(DataModeEnable), 19'(v.expDme));
    if (v.expBv) begin
      checkVal({tag, " ByteOut"}, 19'(ByteOut), 19'(v.expBo));
    end
  endtask

  task automatic applyStimulus(vec_t v);
    WriteValid = v.wv;
    WriteAddr  = v.addr;
    WriteData  = v.data;
    ByteReady  = v.br;
  endtask

  task automatic runVector(vec_t v, string tag);
    @(negedge Clk);
    checkOutput(v, tag);
    applyStimulus(v);
  endtask

  task automatic resetDut();
    @(negedge Clk);
    Reset      = 1'b1;
    WriteValid = 1'b0;
    WriteAddr  = '0;
    WriteData  = '0;
    ByteReady  = 1'b0;
    repeat (2) @(negedge Clk);
    checkVal("reset WriteReady", 19'(WriteReady), 19'(0));
    checkVal("reset ByteValid", 19'(ByteValid), 19'(0));
    checkVal("reset ByteOut", 19'(ByteOut), 19'(0));
    checkVal("reset DataModeEnable", 19'(DataModeEnable), 19'(0));
    Reset = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    Reset      = 1'b1;
    WriteValid = 1'b0;
    WriteAddr  = '0;
    WriteData  = '0;
    ByteReady  = 1'b0;

    // Main table:  wv  addr       data   br  WR  BV  BO     DME
    // first write, full SetAddr then guard cycle and data
    vecs.push_back(mkVec(1, 19'h12345, 8'hAA, 1, 1, 0, 8'h00, 0));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h01, 0));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h01, 0));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h23, 0));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h45, 0));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'hAA, 1));
    // contiguous writes stream data only
    vecs.push_back(mkVec(1, 19'h12346, 8'hBB, 1, 1, 0, 8'h00, 1));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'hBB, 1));
    vecs.push_back(mkVec(1, 19'h12347, 8'hCC, 1, 1, 0, 8'h00, 1));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'hCC, 1));
    // jump to 0x00010: unmode cycle then SetAddr
    vecs.push_back(mkVec(1, 19'h00010, 8'h55, 1, 1, 0, 8'h00, 1));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 0, 8'h00, 1));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h01, 0));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h00, 0));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h00, 0));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h10, 0));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h55, 1));
    // write at top of address space
    vecs.push_back(mkVec(1, 19'h7FFFF, 8'h11, 1, 1, 0, 8'h00, 1));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 0, 8'h00, 1));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h01, 0));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h07, 0));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'hFF, 0));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'hFF, 0));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h11, 1));
    // wrap to 0x00000 is contiguous
    vecs.push_back(mkVec(1, 19'h00000, 8'h22, 1, 1, 0, 8'h00, 1));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h22, 1));
    vecs.push_back(mkVec(0, 19'h00000, 8'h00, 1, 1, 0, 8'h00, 1));

    resetDut();
    for (int i = 0; i < vecs.size(); i++) begin
      runVector(vecs[i], $sformatf("main[%0d]", i));
    end

    // Back-pressure: stall 5 cycles on the HIGH byte, 1 cycle on data.
    resetDut();
    runVector(mkVec(1, 19'h12345, 8'hAA, 1, 1, 0, 8'h00, 0), "stall cmd-accept");
    runVector(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h01, 0), "stall cmd");
    runVector(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h01, 0), "stall page");
    for (int i = 0; i < 5; i++) begin
      runVector(mkVec(0, 19'h00000, 8'h00, 0, 0, 1, 8'h23, 0), $sformatf("stall high[%0d]", i));
    end
    runVector(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h23, 0), "stall high release");
    runVector(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h45, 0), "stall low");
    runVector(mkVec(0, 19'h00000, 8'h00, 1, 0, 0, 8'h00, 0), "stall guard");
    runVector(mkVec(0, 19'h00000, 8'h00, 0, 0, 1, 8'hAA, 1), "stall data hold");
    runVector(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'hAA, 1), "stall data release");

    // Idle timeout: 16 idle cycles in data mode, then the flag drops.
    for (int i = 0; i < 16; i++) begin
      runVector(mkVec(0, 19'h00000, 8'h00, 1, 1, 0, 8'h00, 1), $sformatf("idle[%0d]", i));
    end
    runVector(mkVec(1, 19'h12346, 8'hBB, 1, 1, 0, 8'h00, 0), "timeout contig accept");
    runVector(mkVec(0, 19'h00000, 8'h00, 1, 0, 0, 8'h00, 0), "timeout guard");
    runVector(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'hBB, 1), "timeout data");

    // Reset asserted while the PAGE byte is pending.
    runVector(mkVec(1, 19'h00020, 8'h33, 1, 1, 0, 8'h00, 1), "mid accept");
    runVector(mkVec(0, 19'h00000, 8'h00, 1, 0, 0, 8'h00, 1), "mid unmode");
    runVector(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h01, 0), "mid cmd");
    runVector(mkVec(0, 19'h00000, 8'h00, 0, 0, 1, 8'h00, 0), "mid page");
    #2 Reset = 1'b1;
    #1;
    checkVal("midreset ByteValid", 19'(ByteValid), 19'(0));
    checkVal("midreset DataModeEnable", 19'(DataModeEnable), 19'(0));
    checkVal("midreset WriteReady", 19'(WriteReady), 19'(0));
    checkVal("midreset ByteOut", 19'(ByteOut), 19'(0));
    WriteValid = 1'b0;
    ByteReady  = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;

    // 0x12347 matched the pre-reset expected address; it must get SetAddr.
    runVector(mkVec(1, 19'h12347, 8'h44, 1, 1, 0, 8'h00, 0), "post accept");
    runVector(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h01, 0), "post cmd");
    runVector(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h01, 0), "post page");
    runVector(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h23, 0), "post high");
    runVector(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h47, 0), "post low");
    runVector(mkVec(0, 19'h00000, 8'h00, 1, 0, 0, 8'h00, 0), "post guard");
    runVector(mkVec(0, 19'h00000, 8'h00, 1, 0, 1, 8'h44, 1), "post data");
    runVector(mkVec(0, 19'h00000, 8'h00, 1, 1, 0, 8'h00, 1), "post idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vcmd_tx.md
Name: vcmd_tx

Overview:
Host-side encoder for the video command byte stream. Takes VRAM write requests (19-bit address plus 8-bit data) and serializes them into the byte protocol the video command receiver decodes. When the address is discontiguous it sends, in command mode, SetAddr (0x01) followed by the page, high and low address bytes. Contiguous writes are streamed as raw data bytes in data mode.

Parameters:
IDLE_CYCLES, 16, cycles with no accepted write in data mode before DataModeEnable drops (0 disables the timeout)

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  asynchronous, active-high reset
WriteValid  in  1  write request present
WriteAddr  in  19  VRAM byte address of the request
WriteData  in  8  VRAM data byte of the request
WriteReady  out  1  request accepted on a cycle where WriteValid & WriteReady
ByteOut  out  8  protocol byte to the link
ByteValid  out  1  ByteOut valid; held until ByteReady
ByteReady  in  1  link accepts ByteOut this cycle
DataModeEnable  out  1  0 = command bytes, 1 = data bytes; never changes while ByteValid=1

Behaviour:
- Reset values: ByteOut=0x00, ByteValid=0, DataModeEnable=0, WriteReady=0 while Reset is high, ExpAddrValid=0, state IDLE.
- Internal registers:
  - HoldAddr/HoldData: one-entry request buffer.
  - ExpAddr (19b): next contiguous address.
  - ExpAddrValid.
  - IdleCnt.
- States: IDLE, CMD, PAGE, HIGH, LOW, MODE, DATA, UNMODE.
- WriteReady=1 only in IDLE. Accepting a request loads the buffer. Transitions on acceptance:
  - ExpAddrValid & DataModeEnable & WriteAddr==ExpAddr goes to DATA.
  - WriteAddr==ExpAddr with DataModeEnable=0 (after timeout) goes to MODE.
  - Otherwise, if DataModeEnable=1, go to UNMODE. If DataModeEnable=0, go to CMD.
- UNMODE: DataModeEnable<=0 with no byte, then CMD on the next cycle.
- Byte states drive ByteValid=1 and hold until ByteReady:
  - CMD: ByteOut=0x01, then PAGE.
  - PAGE: ByteOut={5'b0, HoldAddr[18:16]}, then HIGH.
  - HIGH: ByteOut=HoldAddr[15:8], then LOW.
  - LOW: ByteOut=HoldAddr[7:0], then MODE.
- MODE: one cycle with DataModeEnable<=1 and ByteValid=0, then DATA. This gives one guard cycle before the first data byte.
- DATA: ByteOut=HoldData, ByteValid=1. On ByteReady:
  - ExpAddr<=HoldAddr+1, wrapping modulo 2^19 (0x7FFFF to 0x00000 counts as contiguous).
  - ExpAddrValid<=1, return to IDLE.
- ByteValid drops in the cycle after the handshake. ByteOut/ByteValid are registered, so no combinational path runs from ByteReady to the outputs.
- Latency:
  - Discontiguous write accepted at cycle 0: 0x01 valid at cycle 1. With ByteReady=1 throughout, the data byte is valid at cycle 6.
  - Contiguous write in data mode: data byte valid at cycle 1.
  - Throughput: at most one data byte every 2 cycles.
- Idle timeout: in IDLE with DataModeEnable=1 and IDLE_CYCLES>0, IdleCnt counts cycles without acceptance. When it reaches IDLE_CYCLES, DataModeEnable<=0 and IdleCnt clears. ExpAddrValid is kept. Any acceptance clears IdleCnt.
- Back-pressure: ByteReady=0 indefinitely stalls the current state. ByteOut, ByteValid and DataModeEnable stay stable.
- Reset mid-sequence: everything returns to reset values and the buffered request is discarded. The first request after reset always sends the full SetAddr sequence.
- WriteAddr==ExpAddr while ExpAddrValid=0 is treated as discontiguous.

Test Plan:
- Reset release, write 0x12345/0xAA, ByteReady=1 -> bytes 0x01,0x01,0x23,0x45 with DataModeEnable=0, guard cycle, then 0xAA with DataModeEnable=1; WriteReady high again next cycle.
- Follow-up writes 0x12346/0xBB and 0x12347/0xCC -> only data bytes 0xBB, 0xCC; no command bytes; DataModeEnable stays 1.
- Write 0x00010/0x55 after data at 0x12347 -> one cycle with DataModeEnable dropping, then 0x01,0x00,0x00,0x10, guard cycle, 0x55.
- Write at 0x7FFFF, then write at 0x00000 -> second write sends data byte only (wrap is contiguous).
- ByteReady held 0 for 5 cycles during the HIGH byte -> ByteOut=0x23 and ByteValid=1 stable for 5 cycles; WriteReady=0; sequence resumes on release.
- IDLE_CYCLES=16, no writes for 16 cycles after a data byte -> DataModeEnable drops. A contiguous write then gives a guard cycle and data only. Separately, Reset asserted during PAGE makes ByteValid=0 and DataModeEnable=0 immediately.
